// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
// Provides the machine word type, the branch-history-table update record
// and the default depth of the update queue that feeds the BHT write port.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  // One resolved branch outcome headed for the local BHT.
  typedef struct packed {
    lc3b_word pc;
    logic     taken;
  } lc3b_bht_update;

  localparam int BHT_UPDATE_QUEUE_DEPTH = 4;

endpackage

// File: rtl/bht_update_fifo.sv
// Generic DEPTH x DATA_W FIFO storage with read/write pointers and occupancy.
// The caller guarantees push only when not full and pop only when not empty;
// this block applies no policy of its own.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset (pointers/count only)
//   push, wdata  write wdata into the tail slot on the rising edge
//   pop          retire the head slot on the rising edge
//   rdata        head slot contents (combinational)
//   count        occupancy, 0..DEPTH
module bht_update_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 17
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      pop,
  output logic [DATA_W-1:0]         rdata,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Storage is deliberately left uncleared by reset; stale contents are
  // only visible while the queue reports empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally on overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/bht_update_queue.sv
// Branch history table update queue.
// Buffers resolved-branch outcomes from execute/mem and drains at most one
// per cycle into the local BHT write port when drain_en allows, so predictor
// writes never land in the middle of a fetch-side stall.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   in_valid, in_pc, in_taken   resolved branch outcome
//   in_ready                    queue not full (depends on count only)
//   drain_en                    pipeline permits a predictor update
//   write, write_pc, taken      predictor write port (combinational)
//   count                       occupancy, 0..DEPTH
// Optional: define BHT_UPDATE_QUEUE_STATS_EN to add saturating 16-bit
// enq_cnt (accepted enqueues) and drop_cnt (cycles with in_valid && !in_ready).
module bht_update_queue
  import lc3b_types::*;
#(
  parameter int DEPTH = BHT_UPDATE_QUEUE_DEPTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  input  lc3b_word                in_pc,
  input  logic                    in_taken,
  output logic                    in_ready,
  input  logic                    drain_en,
  output logic                    write,
  output lc3b_word                write_pc,
  output logic                    taken,
`ifdef BHT_UPDATE_QUEUE_STATS_EN
  output logic [15:0]             enq_cnt,
  output logic [15:0]             drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);

  lc3b_bht_update wdata;
  lc3b_bht_update rdata;
  logic           push;
  logic           pop;

  // No full pass-through: a full queue refuses input even while draining,
  // which keeps in_ready a pure function of count.
  assign in_ready = (count != (PTR_W+1)'(DEPTH));
  assign push     = in_valid && in_ready;
  assign write    = (count != '0) && drain_en;
  assign pop      = write;

  assign wdata.pc    = in_pc;
  assign wdata.taken = in_taken;
  assign write_pc    = rdata.pc;
  assign taken       = rdata.taken;

  bht_update_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W ($bits(lc3b_bht_update))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .count (count)
  );

`ifdef BHT_UPDATE_QUEUE_STATS_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enq_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (push)                  enq_cnt  <= sat_inc(enq_cnt);
      if (in_valid && !in_ready) drop_cnt <= sat_inc(drop_cnt);
    end
  end
`endif

endmodule

// File: tb/tb_bht_update_queue.sv
module tb_bht_update_queue;
  import lc3b_types::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_pc;
  logic        in_taken;
  logic        in_ready;
  logic        drain_en;
  logic        write;
  logic [15:0] write_pc;
  logic        taken;
  logic [2:0]  count;
`ifdef BHT_UPDATE_QUEUE_STATS_EN
  logic [15:0] enq_cnt;
  logic [15:0] drop_cnt;
`endif

  always #5 clk = ~clk;

  bht_update_queue #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_pc    (in_pc),
    .in_taken (in_taken),
    .in_ready (in_ready),
    .drain_en (drain_en),
    .write    (write),
    .write_pc (write_pc),
    .taken    (taken),
`ifdef BHT_UPDATE_QUEUE_STATS_EN
    .enq_cnt  (enq_cnt),
    .drop_cnt (drop_cnt),
`endif
    .count    (count)
  );

  // Reference model: a plain FIFO of outcomes plus event counters.
  typedef struct {
    logic [15:0] pc;
    logic        t;
  } ent_t;

  ent_t mq[$];
  int   m_enq;
  int   m_drop;
  int   n_pass;
  int   n_total;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
  endtask

  // One cycle: drive at negedge, check combinational outputs, then advance
  // the model at the rising edge.
  task automatic step(input logic v, input logic [15:0] pc, input logic t, input logic d);
    logic exp_w;
    logic acc;
    ent_t e;
    @(negedge clk);
    in_valid = v;
    in_pc    = pc;
    in_taken = t;
    drain_en = d;
    #1;
    exp_w = (mq.size() != 0) && d;
    acc   = v && (mq.size() < DEPTH);
    chk("count", 32'(count), 32'(mq.size()));
    chk("in_ready", 32'(in_ready), 32'(mq.size() != DEPTH));
    chk("write", 32'(write), 32'(exp_w));
    if (exp_w) begin
      chk("write_pc", 32'(write_pc), 32'(mq[0].pc));
      chk("taken", 32'(taken), 32'(mq[0].t));
    end
`ifdef BHT_UPDATE_QUEUE_STATS_EN
    chk("enq_cnt", 32'(enq_cnt), 32'(m_enq));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
`endif
    @(posedge clk);
    if (exp_w) void'(mq.pop_front());
    if (acc) begin
      e.pc = pc;
      e.t  = t;
      mq.push_back(e);
      if (m_enq < 65535) m_enq++;
    end else if (v) begin
      if (m_drop < 65535) m_drop++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0; m_enq = 0; m_drop = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_taken = 1'b0; drain_en = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_write", 32'(write), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic single update.
    step(1'b1, 16'h3002, 1'b1, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Fill past capacity with drain held off, then drain.
    for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + 16'(i), i[0], 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Steady state at count=2 with simultaneous enqueue and dequeue.
    step(1'b1, 16'h5000, 1'b0, 1'b0);
    step(1'b1, 16'h5001, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b1, 16'h5100 + 16'(i), i[0], 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Pointer wrap with alternating outcomes.
    for (int i = 0; i < 10; i++) step(1'b1, 16'h6000 + 16'(i), i[0], 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Full plus drain: input refused while full.
    for (int i = 0; i < 4; i++) step(1'b1, 16'h7000 + 16'(i), 1'b1, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 1'b0, 1'b0);

    // Asynchronous reset mid-traffic discards queued updates.
    step(1'b0, 16'h0000, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    drain_en = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_count", 32'(count), 32'd0);
    chk("rst_mid_write", 32'(write), 32'd0);
    chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
    mq.delete();
    m_enq = 0;
    m_drop = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) step(1'b0, 16'h0000, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bht_update_queue.md
Name: bht_update_queue

Overview:
- Sits directly upstream of the local branch history table's write port.
- Accepts resolved-branch outcomes (PC, taken) from the execute/mem stage and buffers them in a small FIFO.
- Drains at most one update per cycle into the predictor (write / write_pc / taken) when pipeline control permits.
- Decouples branch resolution timing from predictor update timing, so fetch-side lookups are never perturbed mid-stall.

Parameters:
- DEPTH, 4, number of queue entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  resolved branch outcome present this cycle.
- in_pc  input  16  PC of resolved branch (lc3b_word).
- in_taken  input  1  1 = branch taken, 0 = not taken.
- in_ready  output  1  queue can accept an entry this cycle.
- drain_en  input  1  pipeline control permits a predictor update this cycle.
- write  output  1  predictor write strobe.
- write_pc  output  16  PC presented to predictor write port.
- taken  output  1  outcome presented to predictor.
- count  output  PTR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH entries of {pc[15:0], taken}. Read pointer rd_ptr and write pointer wr_ptr are PTR_W bits and wrap modulo DEPTH. Occupancy count is PTR_W+1 bits.
- Reset (async, rst_n low): rd_ptr=0, wr_ptr=0, count=0. Outputs: in_ready=1, write=0, count=0. write_pc and taken hold entry[0] contents, which are don't-care while write=0. Entry storage is not cleared.
- Reset mid-operation: all queued updates are discarded. No write pulse occurs during or on the cycle after reset deassertion unless an entry has been enqueued since.
- in_ready = (count != DEPTH). It is combinational from count only and does not depend on in_valid or drain_en.
- Enqueue: in_valid && in_ready at a rising edge writes {in_pc, in_taken} to entry[wr_ptr] and increments wr_ptr.
- Dequeue: write = (count != 0) && drain_en, combinational. write_pc and taken are combinational from entry[rd_ptr]. When write=1 at a rising edge, rd_ptr increments.
- Latency: an entry enqueued at edge N can produce write=1 no earlier than the cycle following edge N. There is no same-cycle bypass from in_* to write.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged. This is legal at any count 1..DEPTH-1.
- Full queue: in_ready=0 even if a dequeue happens that cycle (no full-pass-through). in_valid while in_ready=0 drops the update. Predictor updates are hints, so a drop affects accuracy only and is not an error.
- Empty queue: write=0 regardless of drain_en. drain_en high with count=0 has no effect.
- Ordering: strict FIFO. Duplicate PCs are not coalescedd; each outcome reaches the predictor in resolution order.
- Pointer wrap: after DEPTH enqueues, wr_ptr returns to 0. Behaviour across the wrap is identical to non-wrap.

Optional Feature:
- Macro BHT_UPDATE_QUEUE_STATS_EN.
- Defined: adds output ports enq_cnt[15:0] and drop_cnt[15:0].
  - enq_cnt increments on every accepted enqueue.
  - drop_cnt increments on every cycle with in_valid && !in_ready.
  - Both saturate at 16'hFFFF, reset to 0 asynchronously, and are readable the cycle after the event.
- Undefined: ports and counters are absent; functional behaviour is otherwise identical.

Decomposition:
- Shared package lc3b_types gets:
  - typedef lc3b_bht_update: packed struct {lc3b_word pc; logic taken;}
  - constant BHT_UPDATE_QUEUE_DEPTH = 4
- Sub-module bht_update_fifo: generic DEPTH×width storage plus pointers and count, with async active-low reset. bht_update_queue wraps it and adds the drain/ready policy and the optional stats.

Test Plan:
- Reset: hold rst_n=0 mid-traffic with count=3 -> count=0, write=0, in_ready=1 immediately. No write pulses after release until a new enqueue.
- Basic: drain_en=1, enqueue {pc=16'h3002, taken=1} at edge N -> write=1, write_pc=16'h3002, taken=1 in cycle after N, count=0 after next edge.
- Fill and drop: drain_en=0, enqueue 5 entries with DEPTH=4 -> count=4, in_ready=0 at 5th. Raise drain_en -> the first 4 PCs drain in order; the 5th is never seen; drop_cnt=1 if stats enabled.
- Simultaneous: count=2, in_valid=1 and drain_en=1 for 6 cycles -> count stays 2 and output PCs follow input order delayed by 2 entries.
- Wrap: 10 enqueue/dequeue pairs with alternating taken -> pointers wrap twice, output sequence matches input exactly.
- Full plus drain: count=4, in_valid=1, drain_en=1 -> in_ready=0, input dropped, count=3 after edge.
